fir_sym_tdm: RTL and testbench

//  Parametrised symmetric (linear-phase) FIR. One shared pre-add/multiply/accumulate datapath is

---
 rtl/fir_pkg.sv | 58 +++++
 rtl/fir_sym_mac.sv | 66 ++++++
 rtl/fir_sym_tdm.sv | 191 +++++++++++++++++++
 tb/tb_fir_sym_tdm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the symmetric time-multiplexed FIR.
// Holds the default 32-tap compensation half-table, the controller state
// encoding and the round/saturate helper used on the accumulator output.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } fsm_state_t;

  localparam int COMP_HALF = 16;

  // Half of the symmetric compensation response; entry 15 is the centre pair.
  // DC gain is 2 * sum = 32768 = 1.0 in Q1.15.
  localparam int FIR_COMP_COEF [COMP_HALF] = '{
    0, -3, 11, -27, 39, -11, -98, 277,
    -392, 203, 471, -1475, 2137, -1328, -2638, 19218
  };

  typedef struct packed {
    logic        sat;
    logic [63:0] value;
  } round_sat_t;

  // Default coefficient for pair k: the compensation table for the 32-tap
  // build, otherwise a centre-pair average (0.5 on the middle pair only).
  function automatic int fir_default_coef(input int k, input int taps, input int fracBits);
    if (taps == 2 * COMP_HALF) return FIR_COMP_COEF[k[3:0]];
    if (k == taps / 2 - 1) return 1 << (fracBits - 1);
    return 0;
  endfunction

  // Round half up by adding 0.5 LSB before the arithmetic shift, then clip
  // to the signed dataW range and flag whether clipping happened.
  function automatic round_sat_t round_sat(input logic signed [63:0] acc,
                                           input int fracBits, input int dataW);
    round_sat_t         r;
    logic signed [63:0] rounded;
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    rounded = (acc + (64'sd1 <<< (fracBits - 1))) >>> fracBits;
    maxV    = (64'sd1 <<< (dataW - 1)) - 64'sd1;
    minV    = -(64'sd1 <<< (dataW - 1));
    r.sat   = 1'b0;
    r.value = rounded;
    if (rounded > maxV) begin
      r.value = maxV;
      r.sat   = 1'b1;
    end else if (rounded < minV) begin
      r.value = minV;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_sym_mac.sv
// Three-stage pre-add / multiply / accumulate pipe shared by all coefficient
// pairs. i_en marks a valid pair entering stage 1; i_clear zeroes the
// accumulator at the start of a new sample.
module fir_sym_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 37
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_tapA,
  input  logic signed [DATA_W-1:0] i_tapB,
  input  logic signed [COEF_W-1:0] i_coef,
  output logic signed [ACC_W-1:0]  o_acc
);

  localparam int PAIR_W = DATA_W + 1;
  localparam int PROD_W = PAIR_W + COEF_W;

  logic signed [PAIR_W-1:0] r_pair;
  logic signed [COEF_W-1:0] r_coef;
  logic                     r_v1;
  logic signed [PROD_W-1:0] r_prod;
  logic                     r_v2;
  logic signed [ACC_W-1:0]  r_acc;

  // Stage 1: symmetric pre-add of the two taps sharing one coefficient.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pair <= '0;
      r_coef <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_pair <= {i_tapA[DATA_W-1], i_tapA} + {i_tapB[DATA_W-1], i_tapB};
      r_coef <= i_coef;
      r_v1   <= i_en;
    end
  end

  // Stage 2: signed multiply of the pair sum by its coefficient.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prod <= '0;
      r_v2   <= 1'b0;
    end else begin
      r_prod <= r_pair * r_coef;
      r_v2   <= r_v1;
    end
  end

  // Stage 3: accumulate valid products; clear wins so a new sample starts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (r_v2) begin
      r_acc <= r_acc + {{(ACC_W - PROD_W){r_prod[PROD_W-1]}}, r_prod};
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fir_sym_tdm.sv
// Symmetric linear-phase FIR with one shared MAC walked over TAPS/2
// coefficient pairs per sample. Build macro FIR_COEF_LOAD_EN adds a
// writable coefficient register file; without it the coefficients are
// the constant default table and the write port is ignored.
module fir_sym_tdm
  import fir_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int COEF_W    = 16,
  parameter  int TAPS      = 32,
  parameter  int FRAC_BITS = 15,
  localparam int HALF      = TAPS / 2,
  localparam int AW        = $clog2(HALF),
  localparam int ACC_W     = DATA_W + 1 + COEF_W + AW,
  localparam int PW        = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_in_valid,
  output logic                     x_in_ready,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     y_out_valid,
  output logic                     y_out_sat,
  input  logic                     coef_wr_en,
  input  logic [AW-1:0]            coef_wr_addr,
  input  logic signed [COEF_W-1:0] coef_wr_data
);

  fsm_state_t               r_state;
  fsm_state_t               w_nextState;
  logic [AW-1:0]            r_pairIdx;
  logic                     r_drainCnt;
  logic [PW-1:0]            r_wrPtr;
  logic [PW-1:0]            r_rdNew;
  logic [PW-1:0]            r_rdOld;
  logic signed [DATA_W-1:0] r_delay [TAPS];
  logic                     w_accept;
  logic                     w_issue;
  logic                     w_outStep;
  logic                     w_ready;
  logic signed [DATA_W-1:0] w_tapNew;
  logic signed [DATA_W-1:0] w_tapOld;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [ACC_W-1:0]  w_acc;
  round_sat_t               w_rs;
  logic                     w_unusedRsHigh;
  logic signed [DATA_W-1:0] r_yOut;
  logic                     r_yValid;
  logic                     r_ySat;

  function automatic logic [PW-1:0] incWrap(input logic [PW-1:0] p);
    return (p == PW'(TAPS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] decWrap(input logic [PW-1:0] p);
    return (p == '0) ? PW'(TAPS - 1) : p - 1'b1;
  endfunction

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // Next state plus per-state strobes: accept in IDLE, issue pairs in RUN,
  // let the MAC pipe empty in DRAIN, publish the result in OUT.
  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_outStep   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (x_in_valid) begin
          w_accept    = 1'b1;
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        w_issue = 1'b1;
        if (r_pairIdx == AW'(HALF - 1)) w_nextState = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drainCnt) w_nextState = ST_OUT;
      end
      ST_OUT: begin
        w_outStep   = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Pair index during RUN and the two-cycle DRAIN counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pairIdx  <= '0;
      r_drainCnt <= 1'b0;
    end else begin
      if (w_accept)     r_pairIdx <= '0;
      else if (w_issue) r_pairIdx <= r_pairIdx + 1'b1;
      if (r_state == ST_DRAIN) r_drainCnt <= ~r_drainCnt;
      else                     r_drainCnt <= 1'b0;
    end
  end

  // Circular delay line. On acceptance the read pointers start at the newest
  // and oldest entries and then walk towards each other, one pair per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) r_delay[i] <= '0;
      r_wrPtr <= '0;
      r_rdNew <= '0;
      r_rdOld <= '0;
    end else if (w_accept) begin
      r_delay[r_wrPtr] <= x_in;
      r_wrPtr          <= incWrap(r_wrPtr);
      r_rdNew          <= r_wrPtr;
      r_rdOld          <= incWrap(r_wrPtr);
    end else if (w_issue) begin
      r_rdNew <= decWrap(r_rdNew);
      r_rdOld <= incWrap(r_rdOld);
    end
  end

  assign w_tapNew = r_delay[r_rdNew];
  assign w_tapOld = r_delay[r_rdOld];

`ifdef FIR_COEF_LOAD_EN
  logic signed [COEF_W-1:0] r_coef [HALF];

  // Coefficient register file; writes only land while idle, so a write in
  // the same cycle as an accepted sample is already visible to its RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < HALF; k++) r_coef[k] <= COEF_W'(fir_default_coef(k, TAPS, FRAC_BITS));
    end else if (coef_wr_en && (r_state == ST_IDLE)) begin
      r_coef[coef_wr_addr] <= coef_wr_data;
    end
  end

  assign w_coef = r_coef[r_pairIdx];
`else
  logic w_unusedCoefWr;

  assign w_coef         = COEF_W'(fir_default_coef(int'(r_pairIdx), TAPS, FRAC_BITS));
  assign w_unusedCoefWr = ^{coef_wr_en, coef_wr_addr, coef_wr_data};
`endif

  fir_sym_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_accept),
    .i_en    (w_issue),
    .i_tapA  (w_tapNew),
    .i_tapB  (w_tapOld),
    .i_coef  (w_coef),
    .o_acc   (w_acc)
  );

  assign w_rs           = round_sat({{(64 - ACC_W){w_acc[ACC_W-1]}}, w_acc}, FRAC_BITS, DATA_W);
  assign w_unusedRsHigh = ^w_rs.value[63:DATA_W];

  // Output register: y_out and y_out_sat hold between results, valid pulses once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_yOut   <= '0;
      r_yValid <= 1'b0;
      r_ySat   <= 1'b0;
    end else begin
      r_yValid <= w_outStep;
      if (w_outStep) begin
        r_yOut <= w_rs.value[DATA_W-1:0];
        r_ySat <= w_rs.sat;
      end
    end
  end

  assign x_in_ready  = w_ready;
  assign y_out       = r_yOut;
  assign y_out_valid = r_yValid;
  assign y_out_sat   = r_ySat;

endmodule

// File: tb/tb_fir_sym_tdm.sv
// Directed bench for fir_sym_tdm (TAPS=32 defaults). Expected values are
// hand-derived from the compensation table: impulse 16384 gives h/2 rounded
// half up; the table has DC gain exactly 1.0.
`timescale 1ns/1ps
module tb_fir_sym_tdm;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] x_in = '0;
  logic               x_in_valid = 1'b0;
  logic               x_in_ready;
  logic signed [15:0] y_out;
  logic               y_out_valid;
  logic               y_out_sat;
  logic               coef_wr_en = 1'b0;
  logic [3:0]         coef_wr_addr = '0;
  logic signed [15:0] coef_wr_data = '0;

  int checks = 0;
  int failures = 0;

`ifdef FIR_COEF_LOAD_EN
  localparam int EXP_IDLE_WR = 500;
  localparam int EXP_BIG_SAT = 1;
`else
  localparam int EXP_IDLE_WR = 9609;
  localparam int EXP_BIG_SAT = 0;
`endif

  typedef struct {
    logic signed [15:0] x;
    int                 expY;
    bit                 expSat;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  fir_sym_tdm #(
    .DATA_W    (16),
    .COEF_W    (16),
    .TAPS      (32),
    .FRAC_BITS (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .x_in         (x_in),
    .x_in_valid   (x_in_valid),
    .x_in_ready   (x_in_ready),
    .y_out        (y_out),
    .y_out_valid  (y_out_valid),
    .y_out_sat    (y_out_sat),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyReset();
    x_in_valid = 1'b0;
    coef_wr_en = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic writeCoef(input int k, input int v);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 4'(k);
    coef_wr_data = 16'(v);
    @(posedge clk); #1;
    coef_wr_en   = 1'b0;
  endtask

  // wrMode: 0 none, 1 write pair 15 with the sample, 2 write pair 15 mid-RUN.
  task automatic applyStimulus(input logic signed [15:0] x, input int wrMode, input int wrData,
                               output int y, output int sat, output int lat, output bit ok);
    int guard;
    ok = 1'b0; y = 0; sat = 0; lat = 0; guard = 0;
    while (!x_in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!x_in_ready) return;
    x_in       = x;
    x_in_valid = 1'b1;
    if (wrMode == 1) begin
      coef_wr_en = 1'b1; coef_wr_addr = 4'd15; coef_wr_data = 16'(wrData);
    end
    @(posedge clk); #1;
    x_in_valid = 1'b0;
    coef_wr_en = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      coef_wr_en = 1'b0;
      if (wrMode == 2 && c == 2) begin
        coef_wr_en = 1'b1; coef_wr_addr = 4'd15; coef_wr_data = 16'(wrData);
      end
      if (y_out_valid) begin
        y = int'(y_out); sat = int'(y_out_sat); lat = c; ok = 1'b1;
        coef_wr_en = 1'b0;
        return;
      end
    end
  endtask

  task automatic sendCheck(input string tag, input logic signed [15:0] x, input int wrMode,
                           input int wrData, input int expY, input int expSat);
    int y, sat, lat;
    bit ok;
    applyStimulus(x, wrMode, wrData, y, sat, lat, ok);
    checkOutput({tag, "_done"}, int'(ok), 1);
    checkOutput({tag, "_y"}, y, expY);
    checkOutput({tag, "_sat"}, sat, expSat);
  endtask

  task automatic sendOnly(input logic signed [15:0] x);
    int y, sat, lat;
    bit ok;
    applyStimulus(x, 0, 0, y, sat, lat, ok);
    checkOutput("warmDone", int'(ok), 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int impY [16] = '{0, -1, 6, -13, 20, -5, -49, 139, -196, 102, 236, -737, 1069, -664, -1319, 9609};
    int accEdge [4];
    int valEdge [4];
    int nAcc, nVal, pulses;
    int y, sat, lat;
    bit ok;

    for (int i = 0; i < 16; i++) begin
      vecs[i].x      = (i == 0) ? 16'sd16384 : 16'sd0;
      vecs[i].expY   = impY[i];
      vecs[i].expSat = 1'b0;
    end

    // Reset state
    applyReset();
    checkOutput("rstY", int'(y_out), 0);
    checkOutput("rstValid", int'(y_out_valid), 0);
    checkOutput("rstSat", int'(y_out_sat), 0);
    checkOutput("rstReady", int'(x_in_ready), 1);

    // Impulse response, with latency check on the first sample
    applyStimulus(vecs[0].x, 0, 0, y, sat, lat, ok);
    checkOutput("imp0_done", int'(ok), 1);
    checkOutput("imp0_y", y, vecs[0].expY);
    checkOutput("imp0_lat", lat, 19);
    for (int i = 1; i < 16; i++)
      sendCheck($sformatf("imp%0d", i), vecs[i].x, 0, 0, vecs[i].expY, int'(vecs[i].expSat));

    // DC at full scale on default coefficients settles without clipping
    for (int i = 0; i < 31; i++) sendOnly(16'sd32767);
    sendCheck("dcPos", 16'sd32767, 0, 0, 32767, 0);

    // Load every pair with 32767 (ignored in the constant-coefficient build)
    for (int k = 0; k < 16; k++) writeCoef(k, 32767);
    sendCheck("bigPos", 16'sd32767, 0, 0, 32767, EXP_BIG_SAT);
    for (int i = 0; i < 31; i++) sendOnly(-16'sd32768);
    sendCheck("bigNeg", -16'sd32768, 0, 0, -32768, EXP_BIG_SAT);

    // Held x_in_valid: one acceptance every 20 cycles, output 19 after each
    applyReset();
    accEdge = '{-1000, -1000, -1000, -1000};
    valEdge = '{-2000, -2000, -2000, -2000};
    nAcc = 0; nVal = 0;
    x_in = '0;
    x_in_valid = 1'b1;
    for (int c = 0; c < 65; c++) begin
      if (x_in_ready && nAcc < 4) begin accEdge[nAcc] = c + 1; nAcc++; end
      if (y_out_valid && nVal < 4) begin valEdge[nVal] = c; nVal++; end
      @(posedge clk); #1;
    end
    x_in_valid = 1'b0;
    checkOutput("thruFirst", accEdge[0], 1);
    checkOutput("thruGap1", accEdge[1] - accEdge[0], 20);
    checkOutput("thruGap2", accEdge[2] - accEdge[1], 20);
    checkOutput("thruLat0", valEdge[0] - accEdge[0], 19);
    checkOutput("thruLat1", valEdge[1] - accEdge[1], 19);

    // Coefficient writes: ignored in RUN, honoured in IDLE with the sample
    applyReset();
    sendOnly(16'sd16384);
    for (int i = 0; i < 14; i++) sendOnly(16'sd0);
    sendCheck("wrRun", 16'sd0, 2, 2000, 9609, 0);
    sendCheck("wrIdle", 16'sd0, 1, 1000, EXP_IDLE_WR, 0);

    // Reset in the middle of RUN aborts the sample and restores defaults
    while (!x_in_ready) begin @(posedge clk); #1; end
    x_in = 16'sd12345;
    x_in_valid = 1'b1;
    @(posedge clk); #1;
    x_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    checkOutput("midRstReady", int'(x_in_ready), 1);
    checkOutput("midRstValid", int'(y_out_valid), 0);
    checkOutput("midRstY", int'(y_out), 0);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (y_out_valid) pulses++;
    end
    checkOutput("midRstPulses", pulses, 0);
    for (int i = 0; i < 16; i++)
      sendCheck($sformatf("postRst%0d", i), vecs[i].x, 0, 0, vecs[i].expY, int'(vecs[i].expSat));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
